knn_vote_merge: RTL and testbench

//  Downstream stage of the update_knn_cluster_* operators in the KNN digit-recognition leaf set.

---
 rtl/knn_pkg.sv | 23 ++
 rtl/knn_sorted_insert.sv | 87 ++++++++
 rtl/knn_vote_merge.sv | 178 +++++++++++++++++
 tb/tb_knn_vote_merge.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared widths, field layout and state encoding for knn_vote_merge
// Contents:
//   DIST_BITS_DEF / LABEL_BITS_DEF : default field widths of a 32-bit stream word
//   LABEL_LSB / DIST_LSB           : field positions within a word {dist, label}
//   state_t                        : merge FSM encoding
//   INVALID_LABEL                  : all-ones pattern; truncate to any label width
package knn_pkg;

  localparam int DIST_BITS_DEF  = 24;
  localparam int LABEL_BITS_DEF = 8;

  localparam int LABEL_LSB = 0;
  localparam int DIST_LSB  = LABEL_BITS_DEF;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VOTE    = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  localparam logic [31:0] INVALID_LABEL = '1;

endpackage

// File: rtl/knn_sorted_insert.sv
// rtl/knn_sorted_insert.sv - K-entry ascending-distance list with single-cycle insert
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   clr                    : synchronous reinitialise to all-ones entries (wins over insert)
//   ins_vld                : insert ins_dist/ins_label this cycle
//   ins_dist, ins_label    : candidate entry
//   head_dist              : distance of entry 0 (nearest)
//   label_flat             : labels of all entries, entry i at [i*LABEL_BITS +: LABEL_BITS]
module knn_sorted_insert
  import knn_pkg::*;
#(
  parameter int K          = 3,
  parameter int DIST_BITS  = DIST_BITS_DEF,
  parameter int LABEL_BITS = LABEL_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    ins_vld,
  input  logic [DIST_BITS-1:0]    ins_dist,
  input  logic [LABEL_BITS-1:0]   ins_label,
  output logic [DIST_BITS-1:0]    head_dist,
  output logic [K*LABEL_BITS-1:0] label_flat
);

  localparam logic [LABEL_BITS-1:0] NO_LABEL = LABEL_BITS'(INVALID_LABEL);

  logic [DIST_BITS-1:0]  dist_q  [K];
  logic [DIST_BITS-1:0]  dist_d  [K];
  logic [LABEL_BITS-1:0] label_q [K];
  logic [LABEL_BITS-1:0] label_d [K];
  logic [K-1:0]          less;

  // The list is always sorted, so "less" is a thermometer code: the first set
  // bit is the insertion slot, every later set bit shifts down by one and the
  // last entry falls off. Strict compare keeps older equal-distance entries ahead.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      less[i]    = (ins_dist < dist_q[i]);
      dist_d[i]  = dist_q[i];
      label_d[i] = label_q[i];
    end
    if (clr) begin
      for (int i = 0; i < K; i++) begin
        dist_d[i]  = '1;
        label_d[i] = NO_LABEL;
      end
    end else if (ins_vld) begin
      if (less[0]) begin
        dist_d[0]  = ins_dist;
        label_d[0] = ins_label;
      end
      for (int i = 1; i < K; i++) begin
        if (less[i]) begin
          if (less[i-1]) begin
            dist_d[i]  = dist_q[i-1];
            label_d[i] = label_q[i-1];
          end else begin
            dist_d[i]  = ins_dist;
            label_d[i] = ins_label;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= '1;
        label_q[i] <= NO_LABEL;
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= dist_d[i];
        label_q[i] <= label_d[i];
      end
    end
  end

  assign head_dist = dist_q[0];

  for (genvar g = 0; g < K; g++) begin : g_flat
    assign label_flat[g*LABEL_BITS +: LABEL_BITS] = label_q[g];
  end

endmodule

// File: rtl/knn_vote_merge.sv
// rtl/knn_vote_merge.sv - merge two cluster KNN streams into a global K list and majority-vote it
// Ports:
//   ap_clk, ap_rst_n                          : clock, asynchronous active-low reset
//   Input_1_V_V / _ap_vld / _ap_ack           : cluster stream 1, {dist, label}
//   Input_2_V_V / _ap_vld / _ap_ack           : cluster stream 2, drained after stream 1
//   Output_1_V_V / _ap_vld / _ap_ack          : result {nearest_dist, winner_label}
module knn_vote_merge
  import knn_pkg::*;
#(
  parameter int K          = 3,
  parameter int K_IN       = 3,
  parameter int DIST_BITS  = DIST_BITS_DEF,
  parameter int LABEL_BITS = LABEL_BITS_DEF,
  parameter int NUM_LABELS = 10
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic [DIST_BITS+LABEL_BITS-1:0] Input_1_V_V,
  input  logic                            Input_1_V_V_ap_vld,
  output logic                            Input_1_V_V_ap_ack,
  input  logic [DIST_BITS+LABEL_BITS-1:0] Input_2_V_V,
  input  logic                            Input_2_V_V_ap_vld,
  output logic                            Input_2_V_V_ap_ack,
  output logic [DIST_BITS+LABEL_BITS-1:0] Output_1_V_V,
  output logic                            Output_1_V_V_ap_vld,
  input  logic                            Output_1_V_V_ap_ack
);

  localparam int CNTW = $clog2(K_IN + 1);
  localparam int VW   = $clog2(K + 1);
  localparam int IW   = (K > 1) ? $clog2(K) : 1;
  localparam logic [LABEL_BITS-1:0] NO_LABEL = LABEL_BITS'(INVALID_LABEL);

  state_t                          state_q, state_d;
  logic                            run_q, run_d;
  logic [CNTW-1:0]                 cnt1_q, cnt1_d;
  logic [CNTW-1:0]                 cnt2_q, cnt2_d;
  logic [IW-1:0]                   vidx_q, vidx_d;
  logic [VW-1:0]                   vcnt_q [NUM_LABELS];
  logic [VW-1:0]                   vcnt_d [NUM_LABELS];
  logic [VW-1:0]                   best_cnt_q, best_cnt_d;
  logic [LABEL_BITS-1:0]           best_lbl_q, best_lbl_d;
  logic [DIST_BITS+LABEL_BITS-1:0] out_data_q, out_data_d;

  logic                            acc1, acc2, last_word, vote_last, list_clr;
  logic [DIST_BITS-1:0]            ins_dist, head_dist;
  logic [LABEL_BITS-1:0]           ins_label, cur_label;
  logic [K*LABEL_BITS-1:0]         label_flat;
  logic [VW-1:0]                   new_cnt;

  assign acc1      = Input_1_V_V_ap_ack & Input_1_V_V_ap_vld;
  assign acc2      = Input_2_V_V_ap_ack & Input_2_V_V_ap_vld;
  assign last_word = acc2 && (cnt2_q == CNTW'(K_IN - 1));
  assign vote_last = (vidx_q == IW'(K - 1));
  assign list_clr  = (state_q == ST_EMIT) && Output_1_V_V_ap_ack;
  assign ins_dist  = acc1 ? Input_1_V_V[DIST_LSB +: DIST_BITS]   : Input_2_V_V[DIST_LSB +: DIST_BITS];
  assign ins_label = acc1 ? Input_1_V_V[LABEL_LSB +: LABEL_BITS] : Input_2_V_V[LABEL_LSB +: LABEL_BITS];

  knn_sorted_insert #(
    .K          (K),
    .DIST_BITS  (DIST_BITS),
    .LABEL_BITS (LABEL_BITS)
  ) u_list (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .clr        (list_clr),
    .ins_vld    (acc1 | acc2),
    .ins_dist   (ins_dist),
    .ins_label  (ins_label),
    .head_dist  (head_dist),
    .label_flat (label_flat)
  );

  // FSM: state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= ST_COLLECT;
    else           state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (last_word)           state_d = ST_VOTE;
      ST_VOTE:    if (vote_last)           state_d = ST_EMIT;
      ST_EMIT:    if (Output_1_V_V_ap_ack) state_d = ST_COLLECT;
      default:                             state_d = ST_COLLECT;
    endcase
  end

  // FSM: outputs. run_q holds acks low during reset and the first cycle after,
  // so an asserted reset drops them at once without a reset-to-ack comb path.
  always_comb begin
    Input_1_V_V_ap_ack  = run_q && (state_q == ST_COLLECT) && (cnt1_q < CNTW'(K_IN));
    Input_2_V_V_ap_ack  = run_q && (state_q == ST_COLLECT) && (cnt1_q == CNTW'(K_IN))
                          && (cnt2_q < CNTW'(K_IN));
    Output_1_V_V_ap_vld = (state_q == ST_EMIT);
  end

  assign Output_1_V_V = out_data_q;

  // Datapath: input counters, vote scan, result capture
  always_comb begin
    run_d      = 1'b1;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    vidx_d     = vidx_q;
    best_cnt_d = best_cnt_q;
    best_lbl_d = best_lbl_q;
    out_data_d = out_data_q;
    new_cnt    = '0;
    cur_label  = NO_LABEL;
    for (int j = 0; j < NUM_LABELS; j++) vcnt_d[j] = vcnt_q[j];
    for (int i = 0; i < K; i++) begin
      if (vidx_q == IW'(i)) cur_label = label_flat[i*LABEL_BITS +: LABEL_BITS];
    end

    case (state_q)
      ST_COLLECT: begin
        if (acc1) cnt1_d = cnt1_q + CNTW'(1);
        if (acc2) cnt2_d = cnt2_q + CNTW'(1);
        if (last_word) begin
          cnt1_d = '0;
          cnt2_d = '0;
        end
      end
      ST_VOTE: begin
        // Strict ">" keeps the label that reached the leading count first.
        for (int j = 0; j < NUM_LABELS; j++) begin
          if (cur_label == LABEL_BITS'(j)) begin
            new_cnt   = vcnt_q[j] + VW'(1);
            vcnt_d[j] = new_cnt;
            if (new_cnt > best_cnt_q) begin
              best_cnt_d = new_cnt;
              best_lbl_d = cur_label;
            end
          end
        end
        vidx_d = vidx_q + IW'(1);
        if (vote_last) begin
          vidx_d     = '0;
          out_data_d = {head_dist, best_lbl_d};
        end
      end
      ST_EMIT: begin
        if (Output_1_V_V_ap_ack) begin
          for (int j = 0; j < NUM_LABELS; j++) vcnt_d[j] = '0;
          best_cnt_d = '0;
          best_lbl_d = NO_LABEL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      run_q      <= 1'b0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      vidx_q     <= '0;
      best_cnt_q <= '0;
      best_lbl_q <= NO_LABEL;
      out_data_q <= '0;
      for (int j = 0; j < NUM_LABELS; j++) vcnt_q[j] <= '0;
    end else begin
      run_q      <= run_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      vidx_q     <= vidx_d;
      best_cnt_q <= best_cnt_d;
      best_lbl_q <= best_lbl_d;
      out_data_q <= out_data_d;
      for (int j = 0; j < NUM_LABELS; j++) vcnt_q[j] <= vcnt_d[j];
    end
  end

endmodule

// File: tb/tb_knn_vote_merge.sv
// tb/tb_knn_vote_merge.sv - self-checking bench for knn_vote_merge (K=3, K_IN=3)
module tb_knn_vote_merge;

  localparam int K    = 3;
  localparam int K_IN = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1, in2, out_data;
  logic        vld1, vld2, ack1, ack2, out_vld, out_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] w1 [3];
  logic [31:0] w2 [3];

  always #5 clk = ~clk;

  knn_vote_merge #(.K(K), .K_IN(K_IN)) dut (
    .ap_clk              (clk),
    .ap_rst_n            (rst_n),
    .Input_1_V_V         (in1),
    .Input_1_V_V_ap_vld  (vld1),
    .Input_1_V_V_ap_ack  (ack1),
    .Input_2_V_V         (in2),
    .Input_2_V_V_ap_vld  (vld2),
    .Input_2_V_V_ap_ack  (ack2),
    .Output_1_V_V        (out_data),
    .Output_1_V_V_ap_vld (out_vld),
    .Output_1_V_V_ap_ack (out_ack)
  );

  // Reference: the kept list is the K first entries of a stable sort by distance
  // of (K invalid placeholders, stream 1 words, stream 2 words). Winner is the
  // valid label that first reaches the final maximum count, nearest first.
  function automatic logic [31:0] model();
    logic [31:0] e [9];
    logic [31:0] t;
    int c [256];
    int mx, win, lb;
    for (int i = 0; i < 3; i++) begin
      e[i]   = 32'hFFFF_FFFF;
      e[3+i] = w1[i];
      e[6+i] = w2[i];
    end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (e[j][31:8] > e[j+1][31:8]) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    for (int i = 0; i < 256; i++) c[i] = 0;
    mx = 0;
    for (int i = 0; i < K; i++) begin
      lb = int'(e[i][7:0]);
      if (lb < 10) begin
        c[lb]++;
        if (c[lb] > mx) mx = c[lb];
      end
    end
    win = 255;
    for (int i = 0; i < 256; i++) c[i] = 0;
    for (int i = 0; i < K; i++) begin
      lb = int'(e[i][7:0]);
      if (lb < 10) begin
        c[lb]++;
        if (mx > 0 && c[lb] == mx && win == 255) win = lb;
      end
    end
    return {e[0][31:8], 8'(win)};
  endfunction

  function automatic logic [31:0] mk(input int d, input int l);
    return {24'(d), 8'(l)};
  endfunction

  task automatic load_case1();
    w1[0] = mk(5, 3); w1[1] = mk(9, 1);  w1[2] = mk(2, 3);
    w2[0] = mk(4, 3); w2[1] = mk(1, 1);  w2[2] = mk(20, 1);
  endtask

  task automatic load_random();
    for (int i = 0; i < 3; i++) begin
      w1[i] = {($urandom_range(9) == 0) ? 24'hFFFFFF : 24'($urandom_range(15)), 8'($urandom_range(12))};
      w2[i] = {($urandom_range(9) == 0) ? 24'hFFFFFF : 24'($urandom_range(15)), 8'($urandom_range(12))};
    end
  endtask

  // Drives both streams from w1/w2; returns at the first negedge after the
  // final transfer. Counts stream-2 acks seen before stream 1 drained.
  task automatic drive_inputs(input int gap_pct, input bit early2,
                              output int bad_ack2, output int bad_vld);
    int i1, i2, cyc;
    bit x1, x2;
    i1 = 0; i2 = 0; cyc = 0; x1 = 0; x2 = 0; bad_ack2 = 0; bad_vld = 0;
    forever begin
      @(negedge clk);
      if (x1) i1++;
      if (x2) i2++;
      if (i1 == 3 && i2 == 3) break;
      cyc++;
      if (cyc > 400) begin
        n_cmp++; n_fail++;
        $display("FAIL input_timeout: accepted %0d/%0d words, required 3/3", i1, i2);
        break;
      end
      vld1 = (i1 < 3) && ($urandom_range(99) >= gap_pct);
      in1  = (i1 < 3) ? w1[i1] : 32'h0;
      vld2 = (i2 < 3) && (early2 || i1 == 3) && ($urandom_range(99) >= gap_pct);
      in2  = (i2 < 3) ? w2[i2] : 32'h0;
      if (ack2 && i1 < 3) bad_ack2++;
      if (out_vld) bad_vld++;
      x1 = vld1 && ack1;
      x2 = vld2 && ack2;
    end
    vld1 = 0; vld2 = 0;
  endtask

  task automatic wait_result(output logic [31:0] data, output int lat);
    lat = 1;
    while (!out_vld) begin
      @(negedge clk);
      lat++;
      if (lat > 100) begin
        n_cmp++; n_fail++;
        $display("FAIL output_timeout: no result vld after %0d cycles", lat);
        break;
      end
    end
    data = out_data;
  endtask

  task automatic accept_result();
    out_ack = 1;
    @(negedge clk);
    out_ack = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; vld1 = 0; vld2 = 0; in1 = 0; in2 = 0; out_ack = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ack1 !== 1'b0)    begin n_fail++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    n_cmp++; if (ack2 !== 1'b0)    begin n_fail++; $display("FAIL reset_ack2: got %b want 0", ack2); end
    n_cmp++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", out_vld); end
    n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (ack1 !== 1'b1)    begin n_fail++; $display("FAIL post_reset_ack1: got %b want 1", ack1); end
    n_cmp++; if (ack2 !== 1'b0)    begin n_fail++; $display("FAIL post_reset_ack2: got %b want 0", ack2); end
  endtask

  task automatic test_basic();
    int ba, bv, lat;
    logic [31:0] d;
    load_case1();
    drive_inputs(0, 0, ba, bv);
    wait_result(d, lat);
    n_cmp++; if (d !== 32'h0000_0103) begin n_fail++; $display("FAIL basic_data: got %h want 00000103", d); end
    n_cmp++; if (lat !== K + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, K + 1); end
    n_cmp++; if (bv !== 0) begin n_fail++; $display("FAIL basic_early_vld: got %0d want 0", bv); end
    accept_result();
    n_cmp++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_drop: got %b want 0", out_vld); end
  endtask

  task automatic test_equal_dist();
    int ba, bv, lat;
    logic [31:0] d;
    w1[0] = mk(7, 2); w1[1] = mk(7, 2); w1[2] = mk(7, 5);
    w2[0] = mk(7, 5); w2[1] = mk(7, 5); w2[2] = mk(7, 5);
    drive_inputs(0, 0, ba, bv);
    wait_result(d, lat);
    n_cmp++; if (d !== 32'h0000_0702) begin n_fail++; $display("FAIL equal_dist_data: got %h want 00000702", d); end
    accept_result();
  endtask

  task automatic test_backpressure();
    int ba, bv, lat;
    logic [31:0] d, held;
    load_case1();
    drive_inputs(0, 0, ba, bv);
    wait_result(held, lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_data !== held || out_vld !== 1'b1 || ack1 !== 1'b0 || ack2 !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: data=%h vld=%b ack1=%b ack2=%b want data=%h vld=1 acks=0",
                 c, out_data, out_vld, ack1, ack2, held);
      end
    end
    accept_result();
    n_cmp++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL hold_single_transfer: vld=%b want 0", out_vld); end
    load_random();
    drive_inputs(0, 0, ba, bv);
    wait_result(d, lat);
    n_cmp++; if (d !== model()) begin n_fail++; $display("FAIL hold_next_instance: got %h want %h", d, model()); end
    accept_result();
  endtask

  task automatic test_in2_early();
    int ba, bv, lat;
    logic [31:0] d;
    load_case1();
    drive_inputs(40, 1, ba, bv);
    wait_result(d, lat);
    n_cmp++; if (ba !== 0) begin n_fail++; $display("FAIL in2_early_ack: %0d early acks, want 0", ba); end
    n_cmp++; if (d !== 32'h0000_0103) begin n_fail++; $display("FAIL in2_early_data: got %h want 00000103", d); end
    accept_result();
  endtask

  task automatic test_invalid_labels();
    int ba, bv, lat;
    logic [31:0] d;
    w1[0] = mk(32, 12); w1[1] = mk(10, 12); w1[2] = mk(85, 12);
    w2[0] = mk(11, 12); w2[1] = mk(99, 12); w2[2] = mk(12, 12);
    drive_inputs(20, 0, ba, bv);
    wait_result(d, lat);
    n_cmp++; if (d !== 32'h0000_0AFF) begin n_fail++; $display("FAIL invalid_labels_data: got %h want 00000AFF", d); end
    accept_result();
  endtask

  task automatic test_reset_mid();
    int n, cyc, ba, bv, lat;
    logic [31:0] d;
    load_case1();
    n = 0; cyc = 0;
    vld1 = 1; in1 = w1[0];
    while (n < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      in1 = w1[n];
      if (ack1) n++;
      @(posedge clk);
    end
    @(negedge clk);
    n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL reset_mid_prefill: accepted %0d want 2", n); end
    rst_n = 0;
    #1;
    n_cmp++; if (ack1 !== 1'b0 || ack2 !== 1'b0 || out_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_drop: ack1=%b ack2=%b vld=%b want 0 0 0", ack1, ack2, out_vld);
    end
    vld1 = 0;
    @(negedge clk);
    rst_n = 1;
    drive_inputs(0, 0, ba, bv);
    wait_result(d, lat);
    n_cmp++; if (d !== 32'h0000_0103) begin n_fail++; $display("FAIL reset_mid_data: got %h want 00000103", d); end
    accept_result();
  endtask

  task automatic test_random();
    int ba, bv, lat;
    logic [31:0] d, exp;
    for (int r = 0; r < 25; r++) begin
      load_random();
      exp = model();
      drive_inputs(int'($urandom_range(50)), 1'($urandom_range(1)), ba, bv);
      wait_result(d, lat);
      n_cmp++; if (d !== exp) begin n_fail++; $display("FAIL random%0d_data: got %h want %h", r, d, exp); end
      n_cmp++; if (ba !== 0) begin n_fail++; $display("FAIL random%0d_in2_ack: %0d early acks, want 0", r, ba); end
      repeat ($urandom_range(3)) @(negedge clk);
      accept_result();
    end
  endtask

  initial begin
    vld1 = 0; vld2 = 0; in1 = 0; in2 = 0; out_ack = 0; rst_n = 0;
    test_reset();
    test_basic();
    test_equal_dist();
    test_backpressure();
    test_in2_early();
    test_invalid_labels();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
